// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer.
//   seq_state_e : sequencer FSM states (hold, staged release, run)
//   rst_cause_e : encoding of rst_cause (00 is never produced)
//   max3        : helper for sizing counters from several cycle counts
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_WDOG = 2'b11
  } rst_cause_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asynchronous assert, synchronous deassert.
// Usable by any block needing a clean local reset from a board-level reset.
// Ports:
//   clk         : clock
//   async_rst_n : asynchronous active-low reset in
//   sync_rst_n  : active-low reset out; drops immediately, rises on the 2nd edge after release
module reset_sync (
  input  logic clk,
  input  logic async_rst_n,
  output logic sync_rst_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign sync_rst_n = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts NUM_OUT synchronous active-high reset lines together, holds them
// HOLD_CYCLES, then releases them one every GAP_CYCLES in index order (bit 0 first).
// A sequence is started by power-on (async_rst_n), a software request in RUN, or, when
// built with RSTSEQ_WDOG_EN defined, a watchdog timeout in RUN.
// Ports:
//   clk         : clock, rising edge
//   async_rst_n : board reset, asynchronous active-low
//   sw_rst_req  : software reset request (pulse or level, honoured only in RUN)
//   wdog_kick   : watchdog service strobe (unused without RSTSEQ_WDOG_EN)
//   rst_out     : sequenced synchronous resets, active-high
//   rst_busy    : any rst_out bit asserted
//   rst_done    : one-cycle pulse in the cycle after the last release
//   rst_cause   : cause of the latest sequence (01 POR, 10 SW, 11 WDOG)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               sw_rst_req,
  input  logic               wdog_kick,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_busy,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);

  localparam int unsigned CntW = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, WDOG_CYCLES)) + 1;
  localparam int unsigned IdxW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_OUT - 1);

  logic arst_sync_n;

  reset_sync u_reset_sync (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sync_rst_n  (arst_sync_n)
  );

  seq_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               done_q, done_d;
  rst_cause_e         cause_q, cause_d;
  logic               wdog_timeout;

`ifdef RSTSEQ_WDOG_EN
  // The sequence must start on the edge where the counter would reach WDOG_CYCLES-1,
  // so fire while it still holds WDOG_CYCLES-2.
  localparam logic [CntW-1:0] WdogFire = CntW'(WDOG_CYCLES - 2);

  logic [CntW-1:0] wdog_cnt_q, wdog_cnt_d;

  always_comb begin
    wdog_timeout = (state_q == StRun) && !wdog_kick && (wdog_cnt_q == WdogFire);
    wdog_cnt_d   = '0;
    // Clears on kick and whenever RUN is being left (sw request or timeout).
    if ((state_q == StRun) && !wdog_kick && !sw_rst_req && !wdog_timeout) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_sync_n) begin
    if (!arst_sync_n) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick;
  assign wdog_timeout     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    cause_d   = cause_q;
    done_d    = 1'b0;

    unique case (state_q)
      StHold: begin
        rst_out_d = '1;
        if (cnt_q == HoldLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRelease: begin
        if (cnt_q == GapLast) begin
          rst_out_d[idx_q] = 1'b0;
          cnt_d            = '0;
          idx_d            = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d   = StRun;
            rst_out_d = '0;
            idx_d     = '0;
            done_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRun: begin
        rst_out_d = '0;
        // Software request takes priority when both land on the same edge.
        if (sw_rst_req || wdog_timeout) begin
          state_d   = StHold;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          cause_d   = sw_rst_req ? CAUSE_SW : CAUSE_WDOG;
        end
      end

      default: begin
        state_d   = StHold;
        cnt_d     = '0;
        idx_d     = '0;
        rst_out_d = '1;
      end
    endcase
  end

  // arst_sync_n already drops asynchronously with async_rst_n, so it alone resets the FSM.
  always_ff @(posedge clk or negedge arst_sync_n) begin
    if (!arst_sync_n) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_busy  = |rst_out_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (NUM_OUT=4, HOLD=16, GAP=8, WDOG=16).
// Stimulus pushes expected output events (edge number, rst_out, rst_done, rst_cause);
// a monitor compares whenever rst_out or rst_done changes. Watchdog scenarios run only
// when RSTSEQ_WDOG_EN is defined.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_rst_n;
  logic       sw_rst_req;
  logic       wdog_kick;
  logic [3:0] rst_out;
  logic       rst_busy;
  logic       rst_done;
  logic [1:0] rst_cause;

  reset_sequencer #(
    .NUM_OUT     (4),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (8),
    .WDOG_CYCLES (16)
  ) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sw_rst_req  (sw_rst_req),
    .wdog_kick   (wdog_kick),
    .rst_out     (rst_out),
    .rst_busy    (rst_busy),
    .rst_done    (rst_done),
    .rst_cause   (rst_cause)
  );

  always #5 clk = ~clk;

  int unsigned ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  rst;
    logic        done;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge count %0d)", nm, act, exp, ecnt);
  endtask

  task automatic push(input int unsigned e, input logic [3:0] r, input logic d,
                      input logic [1:0] c);
    exp_t x;
    x.edge_n = e;
    x.rst    = r;
    x.done   = d;
    x.cause  = c;
    exp_q.push_back(x);
  endtask

  // POR: E1 is the first edge after release; bits fall at E26/E34/E42/E50.
  task automatic por_expect(input int unsigned base);
    push(base + 26, 4'b1110, 1'b0, 2'b01);
    push(base + 34, 4'b1100, 1'b0, 2'b01);
    push(base + 42, 4'b1000, 1'b0, 2'b01);
    push(base + 50, 4'b0000, 1'b1, 2'b01);
    push(base + 51, 4'b0000, 1'b0, 2'b01);
  endtask

  // Sequence started at edge s: all ones at s, releases at s+24..s+48.
  task automatic seq_expect(input int unsigned s, input logic [1:0] c, input bit tail_done);
    push(s,      4'b1111, 1'b0, c);
    push(s + 24, 4'b1110, 1'b0, c);
    push(s + 32, 4'b1100, 1'b0, c);
    push(s + 40, 4'b1000, 1'b0, c);
    push(s + 48, 4'b0000, 1'b1, c);
    if (tail_done) push(s + 49, 4'b0000, 1'b0, c);
  endtask

  task automatic wait_until(input int unsigned t);
    while (ecnt < t) @(negedge clk);
  endtask

  // Monitor
  logic [3:0] prev_out  = 4'b1111;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].edge_n < ecnt) begin
      e = exp_q.pop_front();
      check("missed_event_edge", ecnt, e.edge_n);
    end
    if (rst_out !== prev_out || rst_done !== prev_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got rst_out=%b rst_done=%b at edge %0d, required none",
                 rst_out, rst_done, ecnt);
      end else begin
        e = exp_q.pop_front();
        check("event_edge", ecnt, e.edge_n);
        check("event_rst_out", 32'(rst_out), 32'(e.rst));
        check("event_rst_done", 32'(rst_done), 32'(e.done));
        check("event_rst_cause", 32'(rst_cause), 32'(e.cause));
        check("event_rst_busy", 32'(rst_busy), 32'(|e.rst));
      end
    end
    prev_out  = rst_out;
    prev_done = rst_done;
  end

  int unsigned base;
  int unsigned s;
  int unsigned s2;

  initial begin
    async_rst_n = 1'b0;
    sw_rst_req  = 1'b0;
    wdog_kick   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rst_out", 32'(rst_out), 32'hF);
    check("reset_rst_busy", 32'(rst_busy), 32'h1);
    check("reset_rst_done", 32'(rst_done), 32'h0);
    check("reset_rst_cause", 32'(rst_cause), 32'h1);

    // Power-on sequence
    @(negedge clk);
    async_rst_n = 1'b1;
    base = ecnt;
    por_expect(base);
    wait_until(base + 55);
    check("run_rst_busy", 32'(rst_busy), 32'h0);

    // Software pulse in RUN
    @(negedge clk);
    sw_rst_req = 1'b1;
    s = ecnt + 1;
    seq_expect(s, 2'b10, 1'b0);
    @(negedge clk);
    sw_rst_req = 1'b0;

    // Request held during RELEASE: ignored until the first RUN edge
    wait_until(s + 30);
    sw_rst_req = 1'b1;
    s2 = s + 49;
    seq_expect(s2, 2'b10, 1'b1);
    wait_until(s2);
    sw_rst_req = 1'b0;
    wait_until(s2 + 55);

    // Async reset from RUN (cause was SW): immediate, no edge needed
    @(posedge clk);
    #2;
    push(ecnt, 4'b1111, 1'b0, 2'b01);
    async_rst_n = 1'b0;
    #1;
    check("async_run_rst_out", 32'(rst_out), 32'hF);
    check("async_run_rst_cause", 32'(rst_cause), 32'h1);
    check("async_run_rst_busy", 32'(rst_busy), 32'h1);

    // POR, then async assert at E30 after bit 0 has been released
    repeat (3) @(negedge clk);
    async_rst_n = 1'b1;
    base = ecnt;
    push(base + 26, 4'b1110, 1'b0, 2'b01);
    wait_until(base + 29);
    @(posedge clk);
    #2;
    push(ecnt, 4'b1111, 1'b0, 2'b01);
    async_rst_n = 1'b0;
    #1;
    check("async_e30_rst_out", 32'(rst_out), 32'hF);
    check("async_e30_rst_done", 32'(rst_done), 32'h0);

    // Full POR timing repeats
    repeat (3) @(negedge clk);
    async_rst_n = 1'b1;
    base = ecnt;
    por_expect(base);
    wait_until(base + 55);

`ifdef RSTSEQ_WDOG_EN
    // No kicks: timeout 15 edges after the counter starts from zero
    @(negedge clk);
    wdog_kick = 1'b0;
    s = ecnt + 15;
    seq_expect(s, 2'b11, 1'b1);
    wait_until(s + 2);
    wdog_kick = 1'b1;
    wait_until(s + 55);

    // Kick every 10 cycles: no sequence expected
    wdog_kick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (9) @(negedge clk);
      wdog_kick = 1'b1;
      @(negedge clk);
      wdog_kick = 1'b0;
    end
    check("kicked_rst_busy", 32'(rst_busy), 32'h0);

    // Software request on the timeout edge: SW cause, single sequence
    s = ecnt + 15;
    seq_expect(s, 2'b10, 1'b1);
    wait_until(s - 1);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    wdog_kick  = 1'b1;
    wait_until(s + 55);
`endif

    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL pending_event: got none, required rst_out=%b at edge %0d", e.rst, e.edge_n);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset generator for the processing pipelines. It takes the board-level asynchronous reset plus software and watchdog reset requests, and drives NUM_OUT active-high synchronous reset lines (sync_rst style) into downstream blocks. All lines are asserted together, held for a programmable time, then released one at a time in index order. It sits at the top of the clock domain, ahead of every pipeline that consumes a synchronous reset.

## Interface
- NUM_OUT, 4, number of sequenced reset outputs (>=1)
- HOLD_CYCLES, 16, cycles all outputs stay asserted after the sequence starts (>=1)
- GAP_CYCLES, 8, cycles between successive releases (>=1)
- WDOG_CYCLES, 1024, watchdog timeout in cycles (>=2; used only with the watchdog compiled in)
- clk  input  1  clock, all logic on rising edge
- async_rst_n  input  1  reset: asynchronous, active-low
- sw_rst_req  input  1  software reset request, single-cycle pulse or level
- wdog_kick  input  1  watchdog service strobe
- rst_out  output  NUM_OUT  synchronous active-high resets; bit 0 released first
- rst_busy  output  1  high while any rst_out bit is asserted
- rst_done  output  1  one-cycle pulse when the last bit is released
- rst_cause  output  2  cause of the last sequence: 01 POR, 10 SW, 11 WDOG; 00 is unused

## Operation
- An internal 2-flop synchronizer produces arst_sync_n, with asynchronous assert and synchronous deassert.
- While async_rst_n or arst_sync_n is low:
  - state=HOLD, cnt=0, idx=0
  - rst_out all 1s, rst_busy=1, rst_done=0, rst_cause=01
  - watchdog counter=0
- FSM states:
  - HOLD: cnt increments each cycle. At cnt==HOLD_CYCLES-1, go to RELEASE with cnt=0, idx=0.
  - RELEASE: cnt increments. At cnt==GAP_CYCLES-1, clear rst_out[idx], set cnt=0, idx++. If idx==NUM_OUT-1 at that edge, go to RUN.
  - RUN: rst_out all 0, rst_busy=0.
    - sw_rst_req=1 at an edge: go to HOLD, set all rst_out to 1 on that same edge, cnt=0, rst_cause=10.
    - Watchdog timeout (see Configuration): same action, rst_cause=11.
    - Both at once: SW wins, rst_cause=10.
- sw_rst_req and wdog_kick are ignored in HOLD and RELEASE. A request is not queued.
- rst_done: registered; high for exactly one cycle after the edge that enters RUN.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, WDOG_CYCLES))+1. Counters never wrap within a state.
- async_rst_n assertion mid-sequence or in RUN: all outputs return to reset values immediately, asynchronously, and the sequence restarts from POR.

## Timing
- E1 is the first rising edge after async_rst_n deasserts. arst_sync_n goes high at E2.
- RELEASE is entered at E(2+HOLD_CYCLES).
- rst_out[i] falls at E(2+HOLD_CYCLES+(i+1)*GAP_CYCLES).
- rst_busy falls and RUN is entered with the last release. rst_done is high during the following cycle.
- Software reset: if sw_rst_req is sampled at edge S, rst_out goes to all 1s at S and rst_out[i] falls at S+HOLD_CYCLES+(i+1)*GAP_CYCLES.
- Defaults give E26, E34, E42 and E50 for bits 0 to 3.

## Configuration
- RSTSEQ_WDOG_EN defined:
  - A watchdog counter runs only in RUN and clears on wdog_kick or on leaving RUN.
  - Kick and timeout on the same edge: kick wins.
  - When the counter reaches WDOG_CYCLES-1 with no kick, a WDOG sequence starts at that edge.
- RSTSEQ_WDOG_EN undefined: there is no counter, wdog_kick is unused, and rst_cause is never 11.

## Structure
- Package reset_seq_pkg holds:
  - the state enum (HOLD, RELEASE, RUN)
  - the rst_cause enum (CAUSE_POR=2'b01, CAUSE_SW=2'b10, CAUSE_WDOG=2'b11)
- Sub-module reset_sync contains the 2-flop async-assert/sync-deassert synchronizer. It is reusable by the downstream pipelines.
- The FSM, counters and output register live in reset_sequencer.

## Test plan
- POR with defaults: deassert async_rst_n -> rst_out 1111 until E26, then 1110, 1100 (E34), 1000 (E42), 0000 (E50). rst_done pulse after E50. rst_cause=01.
- SW reset in RUN: sw_rst_req pulse at edge S -> rst_out=1111 at S, bit 0 falls at S+24, done after S+48, rst_cause=10.
- sw_rst_req held high during RELEASE -> ignored until RUN, then a new sequence starts on the first RUN edge with sw_rst_req high.
- async_rst_n asserted at E30 (bit 0 already released) -> rst_out=1111 immediately with no clock edge needed. On deassert the full POR timing repeats.
- With RSTSEQ_WDOG_EN, WDOG_CYCLES=16, no kicks -> sequence starts 15 edges after RUN entry, rst_cause=11. A kick every 10 cycles -> no reset.
- Same-edge sw_rst_req and watchdog timeout -> rst_cause=10, a single sequence.
